// File: rtl/cordic_sincos_loader.sv
// cordic_sincos_loader
// Upstream stage of the 3x3 Givens rotation Q-matrix builder. A set of three
// Q4.12 angles is latched on go. Each angle is range-limited to +/-pi/2, and
// an iterative rotation-mode CORDIC turns it into a sin/cos pair. Each pair
// is written to the Q-matrix block through its load/addr port. After the
// third pair, that block's start input is pulsed.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   go            request to process a new angle set (sampled in IDLE only)
//   theta0..2     signed angles, radians, Q4.12
//   sin, cos      registered signed results, Q4.12
//   addr          angle index 0..2 of the current load
//   load          one-cycle write strobe for sin/cos/addr
//   start         one-cycle strobe after all three loads
//   busy          high while a set is in progress
//   err           sticky saturation flag, cleared on the next accepted go
module cordic_sincos_loader #(
  parameter int STG  = 12,
  parameter int SIZE = 16,
  parameter int INT  = 4,
  parameter int FRAC = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic signed [SIZE-1:0] theta0,
  input  logic signed [SIZE-1:0] theta1,
  input  logic signed [SIZE-1:0] theta2,
  output logic signed [SIZE-1:0] sin,
  output logic signed [SIZE-1:0] cos,
  output logic [1:0]             addr,
  output logic                   load,
  output logic                   start,
  output logic                   busy,
  output logic                   err
);

  // The fixed-point format must describe the whole data word.
  if (INT + FRAC != SIZE) begin : g_bad_format
    $error("cordic_sincos_loader: INT + FRAC must equal SIZE");
  end

  localparam int XW = SIZE + 2;
  localparam int ZW = SIZE + 1;
  localparam int IW = $clog2(STG) + 1;

  localparam logic signed [SIZE-1:0] HALF_PI     = SIZE'(6434);
  localparam logic signed [SIZE-1:0] NEG_HALF_PI = -HALF_PI;
  // Initial x is the CORDIC gain compensation 1/1.64676 in Q4.12.
  localparam logic signed [XW-1:0]   K_INIT      = XW'(2487);
  localparam logic signed [XW-1:0]   OUT_MAX     = {{(XW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [XW-1:0]   OUT_MIN     = {{(XW-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ITER,
    WRITE,
    START
  } state_t;

  state_t state, state_nxt;

  logic signed [SIZE-1:0] th_q [3];
  logic signed [SIZE-1:0] th_sel;
  logic [1:0]             k;
  logic [IW-1:0]          i;
  logic signed [XW-1:0]   x, y;
  logic signed [ZW-1:0]   z;
  logic signed [XW-1:0]   x_sh, y_sh, x_nxt, y_nxt;
  logic signed [ZW-1:0]   atan_z, z_nxt;
  logic                   last_iter;

  // arctan(2^-idx) in Q4.12; entries past the listed depth contribute nothing.
  function automatic logic [SIZE-1:0] atan_lut(input logic [IW-1:0] idx);
    logic [SIZE-1:0] r;
    case (int'(idx))
      0:       r = SIZE'(3217);
      1:       r = SIZE'(1899);
      2:       r = SIZE'(1003);
      3:       r = SIZE'(509);
      4:       r = SIZE'(256);
      5:       r = SIZE'(128);
      6:       r = SIZE'(64);
      7:       r = SIZE'(32);
      8:       r = SIZE'(16);
      9:       r = SIZE'(8);
      10:      r = SIZE'(4);
      11:      r = SIZE'(2);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Clamp an angle into the CORDIC convergence range of +/-pi/2.
  function automatic logic signed [SIZE-1:0] sat_angle(input logic signed [SIZE-1:0] th);
    logic signed [SIZE-1:0] r;
    if (th > HALF_PI)          r = HALF_PI;
    else if (th < NEG_HALF_PI) r = NEG_HALF_PI;
    else                       r = th;
    return r;
  endfunction

  function automatic logic out_of_range(input logic signed [SIZE-1:0] th);
    return (th > HALF_PI) || (th < NEG_HALF_PI);
  endfunction

  // Narrow the wide x/y datapath to the output width, clamping on overflow.
  function automatic logic signed [SIZE-1:0] sat_out(input logic signed [XW-1:0] v);
    logic signed [SIZE-1:0] r;
    if (v > OUT_MAX)      r = OUT_MAX[SIZE-1:0];
    else if (v < OUT_MIN) r = OUT_MIN[SIZE-1:0];
    else                  r = v[SIZE-1:0];
    return r;
  endfunction

  // One micro-rotation. The direction follows the sign of the residual angle.
  always_comb begin
    th_sel = '0;
    case (k)
      2'd0:    th_sel = th_q[0];
      2'd1:    th_sel = th_q[1];
      2'd2:    th_sel = th_q[2];
      default: th_sel = '0;
    endcase

    x_sh      = x >>> i;
    y_sh      = y >>> i;
    atan_z    = signed'({1'b0, atan_lut(i)});
    last_iter = (i == IW'(STG - 1));

    if (!z[ZW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_z;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_z;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one INIT, STG ITER and one WRITE cycle per angle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = INIT;
      INIT:    state_nxt = ITER;
      ITER:    if (last_iter) state_nxt = WRITE;
      WRITE:   state_nxt = (k == 2'd2) ? START : INIT;
      START:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers. The strobes and busy are registered from
  // the next state so that they line up exactly with the state they describe.
  // sin/cos are captured from the final micro-rotation, so they are already
  // valid in the cycle where load is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q[0] <= '0;
      th_q[1] <= '0;
      th_q[2] <= '0;
      k       <= '0;
      i       <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      sin     <= '0;
      cos     <= '0;
      addr    <= '0;
      load    <= 1'b0;
      start   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      load  <= (state_nxt == WRITE);
      start <= (state_nxt == START);
      busy  <= (state_nxt != IDLE);

      case (state)
        IDLE: begin
          if (go) begin
            th_q[0] <= sat_angle(theta0);
            th_q[1] <= sat_angle(theta1);
            th_q[2] <= sat_angle(theta2);
            err     <= out_of_range(theta0) | out_of_range(theta1) | out_of_range(theta2);
            k       <= '0;
          end
        end
        INIT: begin
          x <= K_INIT;
          y <= '0;
          z <= {th_sel[SIZE-1], th_sel};
          i <= '0;
        end
        ITER: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          i <= i + IW'(1);
          if (last_iter) begin
            cos  <= sat_out(x_nxt);
            sin  <= sat_out(y_nxt);
            addr <= k;
          end
        end
        WRITE: begin
          k <= k + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos_loader.sv
// tb_cordic_sincos_loader
// Scoreboard bench for cordic_sincos_loader. Every accepted go pushes the
// three expected loads and the expected start into queues. The expected
// values come from real-valued $sin/$cos of the range-limited angle, and the
// expected cycles come from the documented latency. A separate monitor pops
// an entry whenever load or start is seen and compares it.
module tb_cordic_sincos_loader;

  localparam int STG  = 12;
  localparam int SIZE = 16;
  localparam int TOL  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   go = 1'b0;
  logic signed [SIZE-1:0] theta0 = '0, theta1 = '0, theta2 = '0;
  logic signed [SIZE-1:0] sin_w, cos_w;
  logic [1:0]             addr;
  logic                   load, start, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int       cyc;
    logic [1:0] addr;
    int       sin_e;
    int       cos_e;
  } load_exp_t;

  load_exp_t load_q[$];
  int        start_q[$];

  cordic_sincos_loader #(.STG(STG), .SIZE(SIZE), .INT(4), .FRAC(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .theta0(theta0),
    .theta1(theta1),
    .theta2(theta2),
    .sin   (sin_w),
    .cos   (cos_w),
    .addr  (addr),
    .load  (load),
    .start (start),
    .busy  (busy),
    .err   (err)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clip(input int th);
    if (th > 6434)  return 6434;
    if (th < -6434) return -6434;
    return th;
  endfunction

  function automatic int ideal(input int th, input bit want_sin);
    real a, v;
    a = real'(clip(th)) / 4096.0;
    v = want_sin ? $sin(a) : $cos(a);
    return int'(v * 4096.0);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_near(input string name, input int actual, input int expected);
    checks++;
    if (actual > expected + TOL || actual < expected - TOL) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", name, actual, expected, TOL, cyc);
    end
  endtask

  // Record what a set accepted with rel-cycle 1 at absolute cycle g must produce.
  task automatic push_expect(input int g, input int t0, input int t1, input int t2,
                             input int n_loads, input bit with_start);
    int th[3];
    load_exp_t e;
    th[0] = t0; th[1] = t1; th[2] = t2;
    for (int a = 0; a < n_loads; a++) begin
      e.cyc   = g + 13 + 14 * a;
      e.addr  = 2'(a);
      e.sin_e = ideal(th[a], 1'b1);
      e.cos_e = ideal(th[a], 1'b0);
      load_q.push_back(e);
    end
    if (with_start) start_q.push_back(g + 42);
  endtask

  // Monitor: compares every strobe the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load && start) checkOutput("load_start_overlap", 1, 0);
      if (load) begin
        if (load_q.size() == 0) begin
          checkOutput("unexpected_load", 1, 0);
        end else begin
          load_exp_t e;
          e = load_q.pop_front();
          checkOutput("load_cycle", cyc, e.cyc);
          checkOutput("load_addr", int'(addr), int'(e.addr));
          check_near("load_sin", int'(sin_w), e.sin_e);
          check_near("load_cos", int'(cos_w), e.cos_e);
        end
      end
      if (start) begin
        if (start_q.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          int sc;
          sc = start_q.pop_front();
          checkOutput("start_cycle", cyc, sc);
        end
      end
    end
  end

  // Issue one set and walk through it. Returns on the rel-cycle 44 sample,
  // where busy must be low again. Extra go pulses land at rel cycles p0/p1
  // (0 = none). With hold_go, go stays high so that the next call is accepted
  // back-to-back.
  task automatic applyStimulus(input int t0, input int t1, input int t2,
                               input int p0, input int p1, input bit hold_go);
    int g;
    bit busy_ok;
    int exp_err;
    exp_err = (clip(t0) != t0 || clip(t1) != t1 || clip(t2) != t2) ? 1 : 0;
    theta0 = SIZE'(t0);
    theta1 = SIZE'(t1);
    theta2 = SIZE'(t2);
    go     = 1'b1;
    @(negedge clk);
    g  = cyc;
    go = hold_go;
    push_expect(g, t0, t1, t2, 3, 1'b1);
    checkOutput("err_after_go", int'(err), exp_err);
    busy_ok = busy;
    for (int rel = 2; rel <= 43; rel++) begin
      go = (rel - 1 == p0 || rel - 1 == p1) ? 1'b1 : hold_go;
      @(negedge clk);
      busy_ok = busy_ok & busy;
    end
    go = hold_go;
    checkOutput("busy_whole_set", int'(busy_ok), 1);
    checkOutput("err_sticky", int'(err), exp_err);
    @(negedge clk);
    checkOutput("busy_drop", int'(busy), 0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sin", int'(sin_w), 0);
    checkOutput("reset_cos", int'(cos_w), 0);
    checkOutput("reset_ctrl", int'({addr, load, start, busy, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero angles, then the reference angle set.
    applyStimulus(0, 0, 0, 0, 0, 1'b0);
    applyStimulus(2145, -3217, 6434, 0, 0, 1'b0);

    // Out-of-range angle sets err; a clean set clears it.
    applyStimulus(0, 8000, -100, 0, 0, 1'b0);
    applyStimulus(1000, -1000, 500, 0, 0, 1'b0);
    applyStimulus(-20000, 0, 32767, 0, 0, 1'b0);

    // go re-pulsed during an active set is ignored.
    applyStimulus(700, -2500, 4000, 5, 30, 1'b0);

    // Reset in the middle of a set: only the first load may have occurred.
    theta0 = SIZE'(1500);
    theta1 = SIZE'(-1500);
    theta2 = SIZE'(3000);
    go = 1'b1;
    @(negedge clk);
    g  = cyc;
    go = 1'b0;
    push_expect(g, 1500, -1500, 3000, 1, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sin", int'(sin_w), 0);
    checkOutput("abort_cos", int'(cos_w), 0);
    checkOutput("abort_ctrl", int'({addr, load, start, busy, err}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("abort_no_pending", load_q.size() + start_q.size(), 0);
    applyStimulus(-3000, 2000, 100, 0, 0, 1'b0);

    // Back-to-back sets with go held high.
    applyStimulus(1234, -4321, 6000, 0, 0, 1'b1);
    applyStimulus(-6434, 3217, -2145, 0, 0, 1'b1);
    applyStimulus(300, 600, 900, 0, 0, 1'b0);

    // Randomized sets, some beyond the range limit.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(int'($urandom_range(16000)) - 8000,
                    int'($urandom_range(16000)) - 8000,
                    int'($urandom_range(16000)) - 8000,
                    int'($urandom_range(40)) + 2, 0, n[0]);
    end

    repeat (5) @(negedge clk);
    checkOutput("load_queue_empty", load_q.size(), 0);
    checkOutput("start_queue_empty", start_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_loader.md
Name: cordic_sincos_loader

Overview:
- Upstream stage of the 3x3 Givens rotation Q-matrix builder.
- Takes three rotation angles in Q4.12 and computes sin/cos for each with an iterative rotation-mode CORDIC.
- Writes each sin/cos pair into the Q-matrix block through its load/addr port, then pulses that block's start input.
- Drives the Q-matrix block directly: sin, cos, addr, load and start connect one-to-one.

Parameters:
- STG, 12, number of CORDIC iterations per angle (also the atan table depth).
- SIZE, 16, data width of angles and of sin/cos outputs.
- INT, 4, integer bits of the signed fixed-point format, sign bit included.
- FRAC, 12, fractional bits; SIZE = INT + FRAC.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  request to process the latched angle set; sampled in IDLE only.
- theta0  input  SIZE  signed angle 0, radians, Q4.12.
- theta1  input  SIZE  signed angle 1, radians, Q4.12.
- theta2  input  SIZE  signed angle 2, radians, Q4.12.
- sin  output  SIZE  signed sine result, Q4.12, registered.
- cos  output  SIZE  signed cosine result, Q4.12, registered.
- addr  output  2  angle index 0..2 for the current load.
- load  output  1  one-cycle write strobe for the sin/cos/addr triple.
- start  output  1  one-cycle strobe to the Q-matrix block after all three loads.
- busy  output  1  high while a set is in progress.
- err  output  1  sticky range-saturation flag; cleared on the next accepted go.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset asserted mid-operation aborts immediately; no further load or start pulses occur.
- States: IDLE -> INIT -> ITER -> WRITE -> (INIT for next angle | START) -> IDLE.
- IDLE:
  - When go=1 at a rising edge: latch theta0..2, set k=0, clear err, set busy=1, go to INIT.
  - go=1 in any other state is ignored.
- Range check at latch:
  - If |theta| > 6434 (pi/2 in Q4.12), saturate that angle to +6434 or -6434 and set err=1.
  - Saturation is applied per angle; err stays set until the next accepted go.
- INIT (1 cycle): x = K = 2487, y = 0, z = theta_k, i = 0.
- ITER (STG cycles, i = 0..STG-1):
  - If z >= 0: x <= x - (y >>> i); y <= y + (x >>> i); z <= z - atan_i.
  - Else: x <= x + (y >>> i); y <= y - (x >>> i); z <= z + atan_i.
  - Shifts are arithmetic. x and y are SIZE+2 bits internally; z is SIZE+1 bits.
- atan table (Q4.12), i = 0..11: 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2. Entries with i >= 12 are 0 when STG > 12.
- WRITE (1 cycle):
  - Output cos = sat_SIZE(x), sin = sat_SIZE(y), addr = k, and load = 1 for this cycle only.
  - Results are truncated, never rounded.
  - Then k <= k+1. If k was 2, go to START; otherwise go to INIT.
- START (1 cycle): start = 1, then go to IDLE. busy drops on the cycle IDLE is re-entered.
- Timing:
  - load for angle k appears (k+1)*(STG+2) cycles after the go edge: cycles 14, 28 and 42 for STG=12.
  - start appears at cycle 43.
  - busy is high on cycles 1..43 inclusive.
- sin, cos and addr hold their last values between load pulses. load and start are never high in the same cycle.
- Accuracy: each output is within ±8 LSB of ideal round(4096·sin/cos(theta)).

Test Plan:
- theta0=0, theta1=0, theta2=0, pulse go -> three loads at cycles 14/28/42 with addr 0/1/2, cos≈4096±8, sin≈0±8; start at cycle 43; err=0.
- theta0=2145 (pi/6), theta1=-3217 (-pi/4), theta2=6434 (pi/2) -> expected pairs:
  - addr0: sin≈2048, cos≈3547.
  - addr1: sin≈-2896, cos≈2896.
  - addr2: sin≈4096, cos≈0.
  - All within ±8 LSB.
- theta1=8000 (out of range) -> err=1 from the cycle after go; addr1 gives sin≈4096, cos≈0. A following go with in-range angles clears err.
- go re-pulsed at cycles 5 and 30 of an active set -> ignored; exactly 3 loads and 1 start occur; busy stays high continuously.
- rst_n low at cycle 20 -> all outputs 0 immediately; no start pulse afterwards; a fresh go after release completes a full set normally.
- Back-to-back sets: go held high continuously -> a new set is accepted on the first IDLE cycle after start; load pulse spacing and values are unchanged.
